// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path: datapath widths, adder-tree latency,
// the collector state type and the requantization saturation helper.
package conv_pkg;

  localparam int unsigned SUM_W        = 28;
  localparam int unsigned OUT_W        = 14;
  localparam int unsigned TREE_LATENCY = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } conv_state_e;

  // Output range bounds, widened to the sum width so comparisons stay signed and lossless.
  localparam logic signed [SUM_W-1:0] OutMaxExt = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OutMinExt = SUM_W'(-(1 << (OUT_W - 1)));

  // Clamp a shifted sum into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] c;
    if (v > OutMaxExt) begin
      c = OutMaxExt;
    end else if (v < OutMinExt) begin
      c = OutMinExt;
    end else begin
      c = v;
    end
    return c[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// Synchronous result FIFO with first-word fall-through: the head entry is visible on head_o
// whenever empty_o is low. Pushes while full and pops while empty are ignored.
module conv_result_fifo #(
  parameter int unsigned Width = 14,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CountW = AddrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CountW'(Depth));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; Depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset because the occupancy count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/conv_output_collector.sv
// Collects adder-tree sums for a convolution run, requantizes them (arithmetic shift then
// saturate to 14 bits) and buffers them for a ready/valid consumer. Issue is throttled so
// buffered plus in-flight results never exceed the FIFO depth.
// Build option: define CONV_COLLECTOR_RELU_EN to clamp negative sums to zero before the shift.
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        total,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [SUM_W-1:0] sum_in,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned FifoAddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned InflW     = $clog2(TREE_LATENCY + 1);
  localparam int unsigned OccW      = FifoAddrW + InflW + 1;

  conv_state_e             state_q;
  logic [CNT_W-1:0]        total_q;
  logic [CNT_W-1:0]        accepted_q;
  logic [CNT_W-1:0]        delivered_q, delivered_d;
  logic [TREE_LATENCY-1:0] vpipe_q;
  logic                    done_q;
  logic                    overflow_q;

  logic [InflW-1:0]        inflight;
  logic [OccW-1:0]         occupancy;
  logic                    issue, capture, push, drop, pop;

  logic signed [SUM_W-1:0] pre_shift;
  logic signed [SUM_W-1:0] shifted;
  logic signed [OUT_W-1:0] requant;

  logic [OUT_W-1:0]        fifo_head;
  logic                    fifo_empty, fifo_full;
  logic [FifoAddrW:0]      fifo_count;

  // Count results currently travelling through the adder tree.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(TREE_LATENCY); i++) begin
      inflight = inflight + InflW'(vpipe_q[i]);
    end
  end

  assign occupancy = OccW'(fifo_count) + OccW'(inflight);

  // Reserve a FIFO slot at issue time, since the adder tree cannot be stalled later.
  assign in_ready = (state_q == StRun) && (accepted_q < total_q) &&
                    (occupancy < OccW'(FIFO_DEPTH));
  assign issue    = in_valid && in_ready;

  assign capture  = vpipe_q[TREE_LATENCY-1];
  assign push     = capture && !fifo_full;
  assign drop     = capture && fifo_full;

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? signed'(fifo_head) : '0;
  assign pop       = out_valid && out_ready;

  // Dropped results still count as delivered so a faulty run can terminate.
  assign delivered_d = delivered_q + CNT_W'(pop) + CNT_W'(drop);

  // Requantize the sum arriving from the adder tree.
  always_comb begin
`ifdef CONV_COLLECTOR_RELU_EN
    pre_shift = sum_in[SUM_W-1] ? '0 : sum_in;
`else
    pre_shift = sum_in;
`endif
    shifted = pre_shift >>> SHIFT;
    requant = sat_out(shifted);
  end

  conv_result_fifo #(
    .Width (OUT_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (requant),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // Run control FSM with issue/delivery bookkeeping and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      total_q     <= '0;
      accepted_q  <= '0;
      delivered_q <= '0;
      vpipe_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      vpipe_q     <= {vpipe_q[TREE_LATENCY-2:0], issue};
      accepted_q  <= accepted_q + CNT_W'(issue);
      delivered_q <= delivered_d;
      done_q      <= 1'b0;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            total_q     <= total;
            accepted_q  <= '0;
            delivered_q <= '0;
            if (total == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (delivered_q == total_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_conv_output_collector.sv
// Self-checking bench for conv_output_collector: directed scenarios plus randomized runs,
// checked against a requantization model computed with plain integer arithmetic.
module tb_conv_output_collector;
  import conv_pkg::*;

  localparam int unsigned Shift = 8;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [CntW-1:0]         total;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [SUM_W-1:0] sum_in;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    done;
  logic                    overflow;

  int n_cmp = 0;
  int n_err = 0;

  conv_output_collector #(
    .SHIFT      (Shift),
    .FIFO_DEPTH (Depth),
    .CNT_W      (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .total     (total),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Adder-tree model: a fixed three-cycle delay, never reset, garbage when idle.
  logic [2:0]              tv = 3'b000;
  logic signed [SUM_W-1:0] ts [3];
  logic signed [SUM_W-1:0] cur_sum;
  logic signed [SUM_W-1:0] junk = '0;

  always @(posedge clk) begin
    tv    <= {tv[1:0], in_valid && in_ready};
    ts[0] <= cur_sum;
    ts[1] <= ts[0];
    ts[2] <= ts[1];
  end

  always @(negedge clk) junk <= SUM_W'($urandom);

  assign sum_in = tv[2] ? ts[2] : junk;

  logic signed [OUT_W-1:0] exp_q [$];

  // Reference requantization: floor division by 2**Shift, then clamp to 14-bit range.
  function automatic logic signed [OUT_W-1:0] ref_q(input logic signed [SUM_W-1:0] s);
    longint v, d, q;
    v = s;
`ifdef CONV_COLLECTOR_RELU_EN
    if (v < 0) v = 0;
`endif
    d = longint'(1) << Shift;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return q[OUT_W-1:0];
  endfunction

  function automatic logic signed [SUM_W-1:0] rand_sum();
    logic signed [SUM_W-1:0] r;
    case ($urandom_range(0, 4))
      0:       r = 28'h7FFFFFF;
      1:       r = 28'h8000000;
      2:       r = SUM_W'($urandom_range(0, 4000000)) - 28'sd2000000;
      default: r = SUM_W'($urandom);
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    total = CntW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer issues for a fixed number of cycles (at most limit accepted); out_ready untouched.
  task automatic issue_for(input int cycles, input int limit, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      in_valid = (cnt < limit);
      cur_sum  = rand_sum();
      #1;
      if (in_valid && in_ready) begin
        cnt++;
        exp_q.push_back(ref_q(cur_sum));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drive issues and consume results until n_got are delivered and done has pulsed.
  task automatic run_loop(input string tag, input int n_issue, input int pre, input int n_got,
                          input int rdy_pct, input int vld_pct,
                          input logic signed [SUM_W-1:0] vals [$]);
    int issued = pre;
    int got    = 0;
    int dones  = 0;
    int cyc    = 0;
    logic signed [OUT_W-1:0] e;
    while ((got < n_got || dones == 0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      in_valid  = (issued < n_issue) && ($urandom_range(0, 99) < vld_pct);
      cur_sum   = (issued < vals.size()) ? vals[issued] : rand_sum();
      #1;
      if (in_valid && in_ready) begin
        issued++;
        exp_q.push_back(ref_q(cur_sum));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        check({tag, " data"}, 32'(out_data), 32'(e));
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, " delivered"}, 32'(got), 32'(n_got));
    check({tag, " done pulses"}, 32'(dones), 32'd1);
    check({tag, " queue drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int seen;
    logic signed [SUM_W-1:0] none [$];
    logic signed [SUM_W-1:0] sat_vals [$];

    reset     = 1'b1;
    start     = 1'b0;
    total     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cur_sum   = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Single result latency: issue in cycle t, result visible in cycle t+4.
    do_start(1);
    in_valid = 1'b1;
    cur_sum  = 28'sd4660;
    #1;
    check("lat in_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("lat early out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("lat out_valid", 32'(out_valid), 32'd1);
    check("lat out_data", 32'(out_data), 32'(ref_q(28'sd4660)));
    check("lat model 18", 32'(ref_q(28'sd4660)), 32'(`ifdef CONV_COLLECTOR_RELU_EN 18 `else 18 `endif));
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (done) seen = 1;
    end
    check("lat done", 32'(seen), 32'd1);
    @(negedge clk);
    check("lat done width", 32'(done), 32'd0);

    // Saturation and negative floor.
    exp_q.delete();
    sat_vals = '{28'h7FFFFFF, 28'h8000000, -28'sd4660, 28'sd4660};
    do_start(4);
    run_loop("sat", 4, 0, 4, 100, 100, sat_vals);

    // Zero-length run goes straight to DONE.
    do_start(0);
    check("zero done", 32'(done), 32'd1);
    check("zero in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("zero done width", 32'(done), 32'd0);
    check("zero out_valid", 32'(out_valid), 32'd0);

    // Backpressure: only FIFO_DEPTH issues may be outstanding.
    exp_q.delete();
    do_start(8);
    issue_for(10, 8, cnt);
    check("bp accepted", 32'(cnt), 32'(Depth));
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp overflow", 32'(overflow), 32'd0);
    check("bp out_valid", 32'(out_valid), 32'd1);
    // A start mid-run must be ignored.
    total = CntW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_loop("bp", 8, cnt, 8, 100, 100, none);
    check("bp overflow end", 32'(overflow), 32'd0);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 20);
      exp_q.delete();
      do_start(n);
      run_loop("rand", n, 0, n, $urandom_range(30, 100), $urandom_range(30, 100), none);
    end

    // Forced violation: capture while the FIFO is full.
    exp_q.delete();
    do_start(5);
    issue_for(8, 4, cnt);
    repeat (3) @(negedge clk);
    check("viol accepted", 32'(cnt), 32'd4);
    check("viol in_ready", 32'(in_ready), 32'd0);
    check("viol pre overflow", 32'(overflow), 32'd0);
    force dut.vpipe_q = 3'b100;
    @(posedge clk);
    #1;
    force dut.vpipe_q = 3'b000;
    @(posedge clk);
    #1;
    release dut.vpipe_q;
    @(negedge clk);
    check("viol overflow", 32'(overflow), 32'd1);
    run_loop("viol", 4, 4, 4, 100, 100, none);
    check("viol overflow sticky", 32'(overflow), 32'd1);
    exp_q.delete();
    do_start(2);
    run_loop("post viol", 2, 0, 2, 100, 100, none);
    check("viol overflow still", 32'(overflow), 32'd1);

    // Reset with two results in flight and two buffered.
    exp_q.delete();
    do_start(6);
    issue_for(4, 4, cnt);
    check("mrst accepted", 32'(cnt), 32'd4);
    @(negedge clk);
    check("mrst buffered", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst out_data", 32'(out_data), 32'd0);
    check("mrst out_valid", 32'(out_valid), 32'd0);
    check("mrst in_ready", 32'(in_ready), 32'd0);
    check("mrst done", 32'(done), 32'd0);
    check("mrst overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mrst late capture", 32'(seen), 32'd0);
    do_start(5);
    run_loop("after rst", 5, 0, 5, 70, 80, none);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
